// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control path: FSM states, opcode
// classes, opcode match constants, ALU selects and the Moore output decode.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_CBZ_EXEC = 4'd9,
        ST_B_EXEC   = 4'd10,
        ST_ILLEGAL  = 4'd11,
        ST_TRAP     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_LDUR = 3'd2,
        CLS_STUR = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_B    = 3'd5
    } op_class_e;

    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
    localparam logic [5:0]  OP_B_HI   = 6'b000101;
    localparam logic [3:0]  OP_R_MID  = 4'b0101;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg2loc;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Pure state-decoded outputs; handshake-gated terms are added in the top.
    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_BR;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                c.reg2loc   = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_CBZ_EXEC: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_PASS_B;
                c.reg2loc       = 1'b1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            ST_B_EXEC: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_ALUOUT;
                c.instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                c.illegal    = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_TRAP: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// Combinational opcode classifier: IR[31:21] -> instruction class used by the
// main control FSM.
module multicycle_control_opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [10:0] instr_op_i,
    output logic [2:0]  op_class_o
);

    always_comb begin
        op_class_o = CLS_NONE;
        if (instr_op_i[10] && (instr_op_i[7:4] == OP_R_MID) && (instr_op_i[2:0] == 3'b000))
            op_class_o = CLS_R;
        else if (instr_op_i == OP_LDUR)
            op_class_o = CLS_LDUR;
        else if (instr_op_i == OP_STUR)
            op_class_o = CLS_STUR;
        else if (instr_op_i[10:3] == OP_CBZ_HI)
            op_class_o = CLS_CBZ;
        else if (instr_op_i[10:5] == OP_B_HI)
            op_class_o = CLS_B;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle LEGv8 datapath with a bounded memory wait.
// Define ILLEGAL_TRAP_EN to lock up in TRAP on undefined opcodes instead of NOP-ing.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] instr_op,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        instr_done,
    output logic        mem_err,
    output logic        illegal
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    op_class_e  cls_q, cls_d, cls_now;
    logic [7:0] wait_q, wait_d;
    ctrl_t      ctrl_q;
    logic [2:0] cls_bits;
    logic       waiting, timeout, fetch_done;

    multicycle_control_opcode_classifier u_classifier (
        .instr_op_i (instr_op),
        .op_class_o (cls_bits)
    );

    assign cls_now    = op_class_e'(cls_bits);
    assign waiting    = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    // mem_ready wins over an expiring wait in the same cycle.
    assign timeout    = waiting && !mem_ready && (wait_q == WAIT_LAST);
    assign fetch_done = (state_q == ST_FETCH) && mem_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d = cls_now;
                case (cls_now)
                    CLS_R:             state_d = ST_R_EXEC;
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM_ADDR;
                    CLS_CBZ:           state_d = ST_CBZ_EXEC;
                    CLS_B:             state_d = ST_B_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = ST_TRAP;
`else
                    default:           state_d = ST_ILLEGAL;
`endif
                endcase
            end
            ST_MEM_ADDR: state_d = (cls_q == CLS_LDUR) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
        if (timeout)
            state_d = ST_FETCH;
        wait_d = (waiting && !mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            wait_q  <= 8'd0;
            ctrl_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            ctrl_q  <= moore_ctrl(state_d);
        end
    end

    assign PCWrite     = ctrl_q.pc_write | fetch_done;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = fetch_done;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign Reg2Loc     = ctrl_q.reg2loc |
                         ((state_q == ST_DECODE) && ((cls_now == CLS_STUR) || (cls_now == CLS_CBZ)));
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign instr_done  = ctrl_q.instr_done | ((state_q == ST_MEM_WR) && mem_ready);
    assign mem_err     = timeout;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, random instruction
// stream against a per-instruction reference model, and timeout/reset corner cases.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] instr_op;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, Reg2Loc, ALUSrcA, instr_done, mem_err, illegal;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .instr_op(instr_op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .mem_err(mem_err), .illegal(illegal)
    );

    logic [18:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                  Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, mem_err, illegal};

    localparam logic [18:0] O_PCW   = 19'h1 << 18;
    localparam logic [18:0] O_PCWC  = 19'h1 << 17;
    localparam logic [18:0] O_IORD  = 19'h1 << 16;
    localparam logic [18:0] O_MRD   = 19'h1 << 15;
    localparam logic [18:0] O_MWR   = 19'h1 << 14;
    localparam logic [18:0] O_IRW   = 19'h1 << 13;
    localparam logic [18:0] O_M2R   = 19'h1 << 12;
    localparam logic [18:0] O_RW    = 19'h1 << 11;
    localparam logic [18:0] O_R2L   = 19'h1 << 10;
    localparam logic [18:0] O_SRCA  = 19'h1 << 9;
    localparam logic [18:0] B_FOUR  = 19'h1 << 7;
    localparam logic [18:0] B_IMM   = 19'h2 << 7;
    localparam logic [18:0] B_BR    = 19'h3 << 7;
    localparam logic [18:0] OP_PASS = 19'h1 << 5;
    localparam logic [18:0] OP_R    = 19'h2 << 5;
    localparam logic [18:0] PCS_BR  = 19'h1 << 3;
    localparam logic [18:0] O_DONE  = 19'h1 << 2;
    localparam logic [18:0] O_ERR   = 19'h1 << 1;
    localparam logic [18:0] O_ILL   = 19'h1;

    localparam int C_NONE = 0, C_R = 1, C_LDUR = 2, C_STUR = 3, C_CBZ = 4, C_B = 5;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADD  = 11'b10001011000;

    int checks = 0;
    int failures = 0;
    int n_cycles, n_rw, n_mw, n_done;

    typedef struct {
        string       name;
        logic [10:0] op;
        int          wf;
        int          wm;
        int          cycles;
        int          rw;
        int          mw;
    } vec_t;

    vec_t vecs[12];

    task automatic check_vec(input string name, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: outputs=%b required=%b", name, got, exp);
        end
    endtask

    task automatic check_num(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: value=%0d required=%0d", name, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [10:0] op);
        int k;
        casez (op)
            11'b1??0101?000: k = C_R;
            11'b11111000010: k = C_LDUR;
            11'b11111000000: k = C_STUR;
            11'b10110100???: k = C_CBZ;
            11'b000101?????: k = C_B;
            default:         k = C_NONE;
        endcase
        return k;
    endfunction

    // One clock: drive mem_ready, compare all outputs mid-cycle, gather stats.
    task automatic step(input logic mr, input logic [18:0] exp, input string name);
        mem_ready = mr;
        @(negedge clk);
        check_vec(name, act, exp);
        n_cycles++;
        if (RegWrite) n_rw++;
        if (MemWrite && mem_ready) n_mw++;
        if (instr_done) n_done++;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the per-cycle control word of one instruction, from FETCH onward.
    task automatic run_instr(input logic [10:0] op, input int wf, input int wm, input string tag);
        int c;
        logic [18:0] d;
        c = classify(op);
        instr_op = op;
        n_cycles = 0; n_rw = 0; n_mw = 0; n_done = 0;
        for (int i = 0; i < wf; i++) step(1'b0, O_MRD | B_FOUR, {tag, ".fetch_wait"});
        step(1'b1, O_MRD | B_FOUR | O_IRW | O_PCW, {tag, ".fetch"});
        d = B_BR;
        if (c == C_STUR || c == C_CBZ) d = d | O_R2L;
        step(rnd(), d, {tag, ".decode"});
        case (c)
            C_R: begin
                step(rnd(), O_SRCA | OP_R, {tag, ".r_exec"});
                step(rnd(), O_RW | O_DONE, {tag, ".r_wb"});
            end
            C_LDUR: begin
                step(rnd(), O_SRCA | B_IMM, {tag, ".addr"});
                for (int i = 0; i < wm; i++) step(1'b0, O_IORD | O_MRD, {tag, ".rd_wait"});
                step(1'b1, O_IORD | O_MRD, {tag, ".rd"});
                step(rnd(), O_RW | O_M2R | O_DONE, {tag, ".wb"});
            end
            C_STUR: begin
                step(rnd(), O_SRCA | B_IMM, {tag, ".addr"});
                for (int i = 0; i < wm; i++) step(1'b0, O_IORD | O_MWR | O_R2L, {tag, ".wr_wait"});
                step(1'b1, O_IORD | O_MWR | O_R2L | O_DONE, {tag, ".wr"});
            end
            C_CBZ: step(rnd(), O_SRCA | OP_PASS | O_R2L | O_PCWC | PCS_BR | O_DONE, {tag, ".cbz"});
            C_B:   step(rnd(), O_PCW | PCS_BR | O_DONE, {tag, ".b"});
            default: step(rnd(), O_ILL | O_DONE, {tag, ".nop"});
        endcase
    endtask

    // Memory stage wait expires: error pulse, no completion, back to FETCH.
    task automatic abort_mem(input logic [10:0] op, input string tag);
        logic [18:0] w;
        instr_op = op;
        n_cycles = 0; n_rw = 0; n_mw = 0; n_done = 0;
        w = (op == LDUR) ? (O_IORD | O_MRD) : (O_IORD | O_MWR | O_R2L);
        step(1'b1, O_MRD | B_FOUR | O_IRW | O_PCW, {tag, ".fetch"});
        step(rnd(), (op == STUR) ? (B_BR | O_R2L) : B_BR, {tag, ".decode"});
        step(rnd(), O_SRCA | B_IMM, {tag, ".addr"});
        for (int i = 0; i < 14; i++) step(1'b0, w, {tag, ".wait"});
        step(1'b0, w | O_ERR, {tag, ".abort"});
        check_num({tag, ".regwrites"}, n_rw, 0);
        check_num({tag, ".done"}, n_done, 0);
        run_instr(ADD, 0, 0, {tag, ".recover"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_lat[6];
        int c, wf, wm;
        logic [10:0] op;

        vecs[0]  = '{"add",        ADD,            0,  0,  4, 1, 0};
        vecs[1]  = '{"sub",        11'b11001011000, 1, 0,  5, 1, 0};
        vecs[2]  = '{"and",        11'b10001010000, 0, 0,  4, 1, 0};
        vecs[3]  = '{"ldur",       LDUR,           0,  0,  5, 1, 0};
        vecs[4]  = '{"ldur_wait3", LDUR,           0,  3,  8, 1, 0};
        vecs[5]  = '{"ldur_edge",  LDUR,           14, 14, 33, 1, 0};
        vecs[6]  = '{"stur",       STUR,           0,  0,  4, 0, 1};
        vecs[7]  = '{"stur_wait",  STUR,           1,  2,  7, 0, 1};
        vecs[8]  = '{"cbz",        11'b10110100101, 0, 0,  3, 0, 0};
        vecs[9]  = '{"cbz_wait",   11'b10110100000, 2, 0,  5, 0, 0};
        vecs[10] = '{"b",          11'b00010111111, 0, 0,  3, 0, 0};
        vecs[11] = '{"b_wait",     11'b00010100000, 3, 0,  6, 0, 0};
        base_lat = '{3, 4, 5, 4, 3, 3};

        reset = 1'b1;
        mem_ready = 1'b1;
        instr_op = ADD;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_hold", act, 19'h0);
        reset = 1'b0;
        step(1'b1, 19'h0, "idle");

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].op, vecs[i].wf, vecs[i].wm, vecs[i].name);
            check_num({vecs[i].name, ".cycles"}, n_cycles, vecs[i].cycles);
            check_num({vecs[i].name, ".regwrites"}, n_rw, vecs[i].rw);
            check_num({vecs[i].name, ".memwrites"}, n_mw, vecs[i].mw);
            check_num({vecs[i].name, ".done"}, n_done, 1);
        end

        // Fetch never completes: error on the 15th wait cycle, IRWrite stays low.
        instr_op = ADD;
        for (int i = 0; i < 14; i++) step(1'b0, O_MRD | B_FOUR, "fetch_to.wait");
        step(1'b0, O_MRD | B_FOUR | O_ERR, "fetch_to.abort");
        run_instr(11'b00010100001, 1, 0, "fetch_to.next");
        check_num("fetch_to.next.cycles", n_cycles, 4);

        abort_mem(LDUR, "rd_to");
        abort_mem(STUR, "wr_to");

        // Asynchronous reset in the middle of a read wait.
        instr_op = LDUR;
        step(1'b1, O_MRD | B_FOUR | O_IRW | O_PCW, "rst_mid.fetch");
        step(1'b0, B_BR, "rst_mid.decode");
        step(1'b0, O_SRCA | B_IMM, "rst_mid.addr");
        step(1'b0, O_IORD | O_MRD, "rst_mid.rd_wait");
        reset = 1'b1;
        #1;
        check_vec("rst_mid.async", act, 19'h0);
        @(posedge clk);
        #1;
        check_vec("rst_mid.held", act, 19'h0);
        reset = 1'b0;
        step(1'b1, 19'h0, "rst_mid.idle");
        step(1'b0, O_MRD | B_FOUR, "rst_mid.fetch_again");
        run_instr(ADD, 0, 0, "rst_mid.add");

        for (int n = 0; n < 40; n++) begin
            c = $urandom_range(1, 5);
            wf = $urandom_range(0, 4);
            wm = $urandom_range(0, 4);
            case (c)
                C_R:    op = {1'b1, 2'($urandom), 4'b0101, 1'($urandom), 3'b000};
                C_LDUR: op = LDUR;
                C_STUR: op = STUR;
                C_CBZ:  op = {8'b10110100, 3'($urandom)};
                default: op = {6'b000101, 5'($urandom)};
            endcase
            run_instr(op, wf, wm, "rand");
            check_num("rand.cycles", n_cycles,
                      base_lat[c] + wf + ((c == C_LDUR || c == C_STUR) ? wm : 0));
            check_num("rand.done", n_done, 1);
        end

`ifdef ILLEGAL_TRAP_EN
        instr_op = 11'b11111111111;
        step(1'b1, O_MRD | B_FOUR | O_IRW | O_PCW, "trap.fetch");
        step(rnd(), B_BR, "trap.decode");
        for (int i = 0; i < 6; i++) step(rnd(), O_ILL, "trap.hold");
`else
        run_instr(11'b11111111111, 0, 0, "illegal");
        check_num("illegal.cycles", n_cycles, 3);
        check_num("illegal.done", n_done, 1);
        run_instr(ADD, 0, 0, "after_illegal");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
